pipe_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage pipeline: FD, DX, XM and MW latches plus the multiply/divide operand latch.
- Generates per-stage enables and bubble-insert selects, with one decision per cycle for each hazard class:
  - load-use stall
  - taken-branch flush
  - multi-cycle multdiv occupancy
- Sits in the processor top level beside the latch chain. It drives the latch `en` pins and the NOP-select muxes in front of the latch IR inputs.
- Latch `clr` pins stay tied to global reset only.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_lu_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and its helpers.
package pipe_hazard_ctrl_pkg;

  // Register-index width used across the pipeline control path.
  localparam int unsigned REG_W = 5;

  // Instruction word muxed into a latch IR input to form a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Multdiv sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Load-use hazard detector: the load in X writes a register that the
// instruction in D reads. Register 0 never hazards.
module lu_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             dx_is_load,
  output logic             lu
);

  // Compare both D sources against the X destination.
  always_comb begin
    lu = dx_is_load && (dx_rd != '0) &&
         ((fd_uses_rs && (fd_rs == dx_rd)) ||
          (fd_uses_rt && (fd_rt == dx_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing controller for the 5-stage pipeline: latch enables,
// bubble selects and multdiv occupancy tracking with a watchdog.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W      = pipe_hazard_ctrl_pkg::REG_W,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             dx_is_load,
  input  logic             dx_is_multdiv,
  input  logic             x_branch_taken,
  input  logic             md_rdy,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_nop,
  output logic             dx_nop,
  output logic             xm_nop,
  output logic             md_en,
  output logic             md_result_sel,
  output logic             md_timeout,
  output logic             md_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT - 1);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             to_flag, to_flag_nxt;
  logic             lu;

  lu_detect #(
    .REG_W(REG_W)
  ) u_lu_detect (
    .fd_rs      (fd_rs),
    .fd_rt      (fd_rt),
    .fd_uses_rs (fd_uses_rs),
    .fd_uses_rt (fd_uses_rt),
    .dx_rd      (dx_rd),
    .dx_is_load (dx_is_load),
    .lu         (lu)
  );

  // State, BUSY-cycle counter and watchdog flag registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      cnt     <= '0;
      to_flag <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      to_flag <= to_flag_nxt;
    end
  end

  // Next-state and per-stage enable/bubble decisions.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    to_flag_nxt   = to_flag;
    pc_en         = 1'b1;
    fd_en         = 1'b1;
    dx_en         = 1'b1;
    xm_en         = 1'b1;
    mw_en         = 1'b1;
    fd_nop        = 1'b0;
    dx_nop        = 1'b0;
    xm_nop        = 1'b0;
    md_en         = 1'b0;
    md_result_sel = 1'b0;
    md_timeout    = 1'b0;
    md_busy       = (state == ISSUE) || (state == BUSY);

    unique case (state)
      IDLE: begin
        if (x_branch_taken) begin
          fd_nop = 1'b1;
          dx_nop = 1'b1;
        end else if (dx_is_multdiv) begin
          md_en     = 1'b1;
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_nop    = 1'b1;
          state_nxt = ISSUE;
        end else if (lu) begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          dx_nop = 1'b1;
        end
      end
      ISSUE: begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        dx_en     = 1'b0;
        xm_nop    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = BUSY;
      end
      BUSY: begin
        pc_en  = 1'b0;
        fd_en  = 1'b0;
        dx_en  = 1'b0;
        xm_nop = 1'b1;
        if (md_rdy) begin
          to_flag_nxt = 1'b0;
          state_nxt   = DONE;
        end else if (cnt == CNT_MAX) begin
          to_flag_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        md_result_sel = 1'b1;
        md_timeout    = to_flag;
        to_flag_nxt   = 1'b0;
        state_nxt     = IDLE;
        if (lu) begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          dx_nop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reset forces the whole pipeline frozen with bubbles selected.
    if (!clr_n) begin
      pc_en         = 1'b0;
      fd_en         = 1'b0;
      dx_en         = 1'b0;
      xm_en         = 1'b0;
      mw_en         = 1'b0;
      fd_nop        = 1'b1;
      dx_nop        = 1'b1;
      xm_nop        = 1'b1;
      md_en         = 1'b0;
      md_result_sel = 1'b0;
      md_timeout    = 1'b0;
      md_busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// output words; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [4:0] fd_rs = '0, fd_rt = '0, dx_rd = '0;
  logic       fd_uses_rs = 1'b0, fd_uses_rt = 1'b0;
  logic       dx_is_load = 1'b0, dx_is_multdiv = 1'b0;
  logic       x_branch_taken = 1'b0, md_rdy = 1'b0;
  logic       pc_en, fd_en, dx_en, xm_en, mw_en;
  logic       fd_nop, dx_nop, xm_nop;
  logic       md_en, md_result_sel, md_timeout, md_busy;

  pipe_hazard_ctrl #(
    .REG_W      (5),
    .MD_TIMEOUT (4),
    .CNT_W      (3)
  ) dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .fd_rs          (fd_rs),
    .fd_rt          (fd_rt),
    .fd_uses_rs     (fd_uses_rs),
    .fd_uses_rt     (fd_uses_rt),
    .dx_rd          (dx_rd),
    .dx_is_load     (dx_is_load),
    .dx_is_multdiv  (dx_is_multdiv),
    .x_branch_taken (x_branch_taken),
    .md_rdy         (md_rdy),
    .pc_en          (pc_en),
    .fd_en          (fd_en),
    .dx_en          (dx_en),
    .xm_en          (xm_en),
    .mw_en          (mw_en),
    .fd_nop         (fd_nop),
    .dx_nop         (dx_nop),
    .xm_nop         (xm_nop),
    .md_en          (md_en),
    .md_result_sel  (md_result_sel),
    .md_timeout     (md_timeout),
    .md_busy        (md_busy)
  );

  always #5 clk = ~clk;

  // Output word: {pc,fd,dx,xm,mw en} {fd,dx,xm nop} {md_en,res_sel,timeout,busy}
  localparam logic [11:0] E_RST  = 12'b00000_111_0000;
  localparam logic [11:0] E_NORM = 12'b11111_000_0000;
  localparam logic [11:0] E_BR   = 12'b11111_110_0000;
  localparam logic [11:0] E_LU   = 12'b00111_010_0000;
  localparam logic [11:0] E_MDGO = 12'b00011_001_1000;
  localparam logic [11:0] E_STL  = 12'b00011_001_0001;
  localparam logic [11:0] E_DONE = 12'b11111_000_0100;
  localparam logic [11:0] E_DTO  = 12'b11111_000_0110;
  localparam logic [11:0] E_DLU  = 12'b00111_010_0100;

  logic [11:0] act;
  assign act = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_nop, dx_nop, xm_nop,
                md_en, md_result_sel, md_timeout, md_busy};

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;

  // Drive one cycle of stimulus just after the edge and queue its expectation.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] rd,
                      input logic ld, input logic md, input logic br, input logic rdy,
                      input string nm, input logic [11:0] e);
    @(posedge clk);
    #1;
    clr_n          = rst;
    fd_rs          = rs;
    fd_rt          = rt;
    fd_uses_rs     = urs;
    fd_uses_rt     = urt;
    dx_rd          = rd;
    dx_is_load     = ld;
    dx_is_multdiv  = md;
    x_branch_taken = br;
    md_rdy         = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic quiet(input string nm, input logic [11:0] e);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, nm, e);
  endtask

  task automatic mdc(input logic rdy, input string nm, input logic [11:0] e);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, rdy, nm, e);
  endtask

  // Monitor: compare the presented output word against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [11:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b want %b", nm, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0", E_RST);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1", E_RST);
    quiet("idle_after_reset", E_NORM);

    // Load-use on rs, then rt; register 0 and unused sources never stall.
    step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, "lu_rs", E_LU);
    quiet("lu_rs_release", E_NORM);
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, "lu_r0", E_NORM);
    step(1, 3, 7, 0, 1, 7, 1, 0, 0, 0, "lu_rt", E_LU);
    step(1, 9, 2, 0, 1, 9, 1, 0, 0, 0, "lu_rs_unused", E_NORM);
    step(1, 5, 0, 1, 0, 5, 0, 0, 0, 0, "lu_not_load", E_NORM);

    // Branch flush, and branch beating a simultaneous multdiv.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "branch", E_BR);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "branch_md", E_BR);
    quiet("branch_after", E_NORM);

    // Multdiv normal: md_rdy in ISSUE ignored, taken in 4th BUSY cycle.
    mdc(0, "md_go", E_MDGO);
    mdc(1, "md_issue", E_STL);
    mdc(0, "md_busy1", E_STL);
    mdc(0, "md_busy2", E_STL);
    mdc(0, "md_busy3", E_STL);
    mdc(1, "md_busy4_rdy", E_STL);
    quiet("md_done", E_DONE);
    quiet("md_idle", E_NORM);

    // Multdiv watchdog: four BUSY cycles then a one-cycle timeout pulse.
    mdc(0, "to_go", E_MDGO);
    mdc(0, "to_issue", E_STL);
    mdc(0, "to_busy1", E_STL);
    mdc(0, "to_busy2", E_STL);
    mdc(0, "to_busy3", E_STL);
    mdc(0, "to_busy4", E_STL);
    quiet("to_done", E_DTO);
    quiet("to_idle", E_NORM);
    quiet("to_idle2", E_NORM);

    // Reset mid-BUSY, then a stray md_rdy must not produce DONE.
    mdc(0, "rb_go", E_MDGO);
    mdc(0, "rb_issue", E_STL);
    mdc(0, "rb_busy1", E_STL);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "rb_reset", E_RST);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rb_stray_rdy", E_NORM);
    quiet("rb_idle1", E_NORM);
    quiet("rb_idle2", E_NORM);

    // DONE cycle carrying a load-use match.
    mdc(0, "dl_go", E_MDGO);
    mdc(0, "dl_issue", E_STL);
    mdc(1, "dl_busy_rdy", E_STL);
    step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, "dl_done_lu", E_DLU);
    quiet("dl_idle", E_NORM);

    // Drain the scoreboard within a bounded number of cycles.
    for (int unsigned i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
